uart_tx_arbiter: RTL

- Wishbone master that configures the memory-mapped UART after reset, then shares its transmit-data register between NUM_REQ byte-stream requesters (e.g. CPU trace port, debug monitor).
- Each accepted byte becomes one Wishbone write to UART_BASE+0x4; the slave's ack (returned at end of serialisation) completes it.
- Sits between requesters and the UART slave port on the peripheral bus.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: UART register map and arbiter state encoding shared by the UART TX arbiter
package uart_pkg;
    localparam logic [31:0] UART_OFF_DIVIDER  = 32'h0;
    localparam logic [31:0] UART_OFF_TXDATA   = 32'h4;
    localparam logic [31:0] UART_OFF_SANITY   = 32'h8;
    localparam logic [31:0] UART_SANITY_VALUE = 32'hA17EB0B0;
    typedef enum logic [2:0] {CFG_WR, CFG_RD, IDLE, XFER, GAP, FAULT} state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr_i with wrap
//   req_i   : request vector
//   ptr_i   : highest-priority index (register lives in the parent)
//   gnt_o   : one-hot grant, idx_o: its index, valid_o: any request granted
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid_o && req_i[(int'(ptr_i) + i) % N]) begin
                valid_o = 1'b1;
                gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
                idx_o = PW'((int'(ptr_i) + i) % N);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: Wishbone master that configures the UART divider, then shares TXDATA between requesters
//   req_valid_i/req_data_i/req_ready_o : per-requester byte streams, ready is a same-cycle one-hot accept
//   wb_*                               : registered Wishbone master port to the UART slave
//   busy_o                             : not idle; cfg_err_o / timeout_err_o sticky errors; tx_count_o acked bytes
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NUM_REQ       = 2,
    parameter int          WB_DATA_WIDTH = 32,
    parameter int          WB_ADDR_WIDTH = 32,
    parameter int          WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
    parameter logic [31:0] UART_BASE     = 32'h0,
    parameter logic [31:0] DIVIDER       = 32'd1,
    parameter int          TIMEOUT_W     = 20
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*8-1:0]     req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
    output logic                     wb_we_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    input  logic                     wb_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    output logic                     busy_o,
    output logic                     cfg_err_o,
    output logic                     timeout_err_o,
    output logic [15:0]              tx_count_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                   state_q, state_d, ret_q, ret_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [TIMEOUT_W-1:0]     tmo_q, tmo_d, tmo_inc;
    logic [15:0]              cnt_q, cnt_d;
    logic                     cfg_err_q, cfg_err_d, tmo_err_q, tmo_err_d;
    logic [7:0]               byte_q, byte_d;
    logic                     cyc_q, cyc_d, we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WB_DATA_WIDTH-1:0] data_q, data_d;
    logic [WB_SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [NUM_REQ-1:0]       gnt, ready;
    logic [PW-1:0]            gnt_idx;
    logic                     gnt_v, ack, expire;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_v)
    );

    // ack only counts while a cycle is open; an ack on the last counted cycle wins over the timeout
    assign ack     = wb_ack_i && cyc_q;
    assign tmo_inc = tmo_q + TIMEOUT_W'(1);
    assign expire  = cyc_q && !wb_ack_i && (tmo_inc == '1);

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        cfg_err_d = cfg_err_q;
        tmo_err_d = tmo_err_q;
        byte_d    = byte_q;
        ready     = '0;
        unique case (state_q)
            CFG_WR: begin
                if (ack) begin
                    state_d = GAP;
                    ret_d   = CFG_RD;
                end else if (expire) begin
                    state_d   = FAULT;
                    cfg_err_d = 1'b1;
                    tmo_err_d = 1'b1;
                end
            end
            CFG_RD: begin
                if (ack && wb_data_i == WB_DATA_WIDTH'(DIVIDER)) begin
                    state_d = GAP;
                    ret_d   = IDLE;
                end else if (ack) begin
                    state_d   = FAULT;
                    cfg_err_d = 1'b1;
                end else if (expire) begin
                    state_d   = FAULT;
                    cfg_err_d = 1'b1;
                    tmo_err_d = 1'b1;
                end
            end
            IDLE: begin
                if (gnt_v && !rst_i) begin
                    ready   = gnt;
                    byte_d  = req_data_i[8*gnt_idx +: 8];
                    ptr_d   = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
                    state_d = XFER;
                end
            end
            XFER: begin
                if (ack) begin
                    state_d = GAP;
                    ret_d   = IDLE;
                    cnt_d   = cnt_q + 16'd1;
                end else if (expire) begin
                    state_d   = GAP;
                    ret_d     = IDLE;
                    tmo_err_d = 1'b1;
                end
            end
            GAP:     state_d = ret_q;
            default: ;
        endcase
        tmo_d  = (state_d != state_q) ? '0 : cyc_q ? tmo_inc : tmo_q;
        // bus outputs are registered from the next state so they line up with it
        cyc_d  = state_d inside {CFG_WR, CFG_RD, XFER};
        we_d   = state_d inside {CFG_WR, XFER};
        addr_d = (state_d == XFER) ? WB_ADDR_WIDTH'(UART_BASE + UART_OFF_TXDATA) :
                 cyc_d ? WB_ADDR_WIDTH'(UART_BASE + UART_OFF_DIVIDER) : '0;
        data_d = (state_d == XFER) ? WB_DATA_WIDTH'(byte_d) :
                 (state_d == CFG_WR) ? WB_DATA_WIDTH'(DIVIDER) : '0;
        sel_d  = (state_d == XFER) ? WB_SEL_WIDTH'(1) : cyc_d ? '1 : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CFG_WR;
            ret_q     <= CFG_WR;
            ptr_q     <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            byte_q    <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            ptr_q     <= ptr_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
            tmo_err_q <= tmo_err_d;
            byte_q    <= byte_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
        end
    end

    assign req_ready_o   = ready;
    assign wb_addr_o     = addr_q;
    assign wb_data_o     = data_q;
    assign wb_sel_o      = sel_q;
    assign wb_we_o       = we_q;
    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = cyc_q;
    assign busy_o        = state_q != IDLE;
    assign cfg_err_o     = cfg_err_q;
    assign timeout_err_o = tmo_err_q;
    assign tx_count_o    = cnt_q;
endmodule
